obstacle_line_scanner: RTL
==========================

# obstacle_line_scanner

Per-scanline reader of the horizon obstacle slot array. During horizontal blanking it walks every obstacle slot, one per cycle, and snapshots up to `MAX_HITS` obstacles that intersect the next display line. During active video it answers, one cycle after each pixel, which buffered obstacle covers that pixel and the sprite-local (u, v) coordinate, for the sprite-ROM fetch stage. It sits between the horizon block's obstacle outputs and the obstacle sprite renderer.

## Interface
Parameters:
- `MAX_OBSTACLES`, 7, number of obstacle slots scanned.
- `MAX_HITS`, 3, line-buffer depth (obstacles kept per line).
- `GAME_WIDTH`, 640, visible width in pixels.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `line_start`  in  1  single-cycle pulse; begin a scan for line `line_y`.
- `line_y`  in  10  y of the line to be scanned.
- `obstacle_start`  in  1×MAX_OBSTACLES  slot-active flags.
- `obstacle_x_pos`  in  signed 11×MAX_OBSTACLES  left edge.
- `obstacle_y_pos`, `obstacle_width`, `obstacle_height`  in  10×MAX_OBSTACLES  top edge and size.
- `obstacle_frame`  in  obstacle_pkg::frame_t×MAX_OBSTACLES  animation frame.
- `pixel_valid`  in  1  `pixel_x` is an active pixel to look up.
- `pixel_x`  in  10  current pixel column.
- `scan_busy`  out  1  scan in progress.
- `scan_done`  out  1  one-cycle pulse when the line buffer is ready.
- `hit_count`  out  2  obstacles buffered for the line.
- `overflow`  out  1  more than `MAX_HITS` obstacles qualified.
- `hit_valid`  out  1  the looked-up pixel is covered.
- `hit_slot`  out  3  slot index of the covering obstacle.
- `hit_u`, `hit_v`  out  10  sprite-local column and row.
- `hit_frame`  out  frame_t  frame of the covering obstacle.

## Operation
- FSM states are IDLE, SCAN and READY.
- IDLE → SCAN on `line_start`.
- SCAN → READY after slot `MAX_OBSTACLES-1` has been evaluated.
- READY stays in READY until the next `line_start`.
- `line_start` in any state, including mid-SCAN, latches `line_y` and performs the following actions:
  - clears the buffer, `hit_count` and `overflow`;
  - restarts the scan at slot 0.
- SCAN evaluates slot `k` in cycle `k`. The slot qualifies when all of the following hold:
  - `obstacle_start[k]`;
  - `y_pos ≤ line_y < y_pos+height`, computed as an 11-bit unsigned compare;
  - `x_pos+width > 0` and `x_pos < GAME_WIDTH`, computed as 12-bit signed compares.
- A qualifying slot is handled as follows:
  - If `hit_count < MAX_HITS`, the entry {slot, x_pos, width, v=line_y−y_pos, frame} is snapshotted into entry `hit_count`, and `hit_count` increments.
  - Otherwise `overflow` is set and the slot is dropped.
- Snapshotted values are frozen. Horizon updates during the line do not affect lookups.
- Lookup happens only in READY with `pixel_valid`:
  - Entry `j` covers the pixel when `x_pos ≤ pixel_x < x_pos+width` (12-bit signed).
  - The lowest entry index wins. Since entries are filled in slot order, this means the lowest slot number wins.
  - `hit_u = pixel_x − x_pos`, truncated to 10 bits. It is always in the range 0..width−1.
- In IDLE and SCAN, or when `pixel_valid`=0, the next `hit_valid`=0. `hit_slot`, `hit_u`, `hit_v` and `hit_frame` hold their previous values.

## Timing
- Reset is asynchronous and active-low. It forces:
  - state IDLE;
  - `scan_busy`, `scan_done`, `hit_count`, `overflow`, `hit_valid`, `hit_slot`, `hit_u`, `hit_v` = 0;
  - `hit_frame` = 0;
  - all buffer entries cleared.
- Scan timing, with `line_start` sampled at edge t:
  - `scan_busy`=1 from t+1 through t+MAX_OBSTACLES.
  - Slots 0..MAX_OBSTACLES−1 are evaluated at edges t+1..t+MAX_OBSTACLES.
  - `scan_done`=1 for exactly the cycle after the last evaluation (t+MAX_OBSTACLES+1, i.e. 8 cycles after t with defaults), and READY starts in that same cycle.
- `hit_count` and `overflow` are valid from the `scan_done` cycle onward and stable until the next `line_start`.
- Lookup latency is 1 cycle. A `pixel_x` sampled at edge p gives registered hit outputs after edge p+1. Full throughput: one pixel per cycle.
- `line_start` coincident with `pixel_valid` has the following effects:
  - the restart wins;
  - that pixel returns `hit_valid`=0;
  - no `scan_done` is generated for the aborted scan.
- Upstream must allow at least MAX_OBSTACLES+1 blanking cycles between `line_start` and the first active pixel.

## Test plan
- **Reset during scan:** assert `rst`=0 three cycles after `line_start` → all outputs 0 immediately, without a clock edge; no `scan_done` after release.
- **Single hit:** slot 2 {x=100, y=50, w=34, h=70}, `line_y`=60 → `scan_done` at t+8, `hit_count`=1. Lookups:
  - `pixel_x`=100 → `hit_valid`=1, slot=2, u=0, v=10.
  - `pixel_x`=133 → u=33.
  - `pixel_x`=99 or 134 → `hit_valid`=0.
- **Left clipping and boundaries:** x=−10, w=25 → `pixel_x`=0 gives u=10; `pixel_x`=15 misses. `line_y`=y+h → slot not buffered. Slot with `obstacle_start`=0 → ignored.
- **Overflow:** slots 0, 1, 3, 5 all cover `line_y` → `hit_count`=3, `overflow`=1; slot 5 is never reported.
- **Overlap priority:** slots 1 and 4 overlap at `pixel_x`=200 → `hit_slot`=1. Changing slot 1 inputs after `scan_done` does not change the result.
- **Restart:** second `line_start` in mid-SCAN or READY → previous buffer cleared; exactly one `scan_done`, 8 cycles after the second pulse.

Source files
------------

// File: rtl/obstacle_pkg.sv
// Shared types for the obstacle pipeline (horizon, line scanner, sprite renderer).
package obstacle_pkg;
   typedef logic [1:0] frame_t;
endpackage

// File: rtl/obstacle_line_scanner_if.sv
// Port bundle for obstacle_line_scanner: horizon slot array, scan control and pixel lookup.
interface obstacle_line_scanner_if #(
   parameter int MAX_OBSTACLES = 7,
   parameter int MAX_HITS      = 3
);
   import obstacle_pkg::*;

   localparam int SLOT_W = (MAX_OBSTACLES > 1) ? $clog2(MAX_OBSTACLES) : 1;
   localparam int CNT_W  = $clog2(MAX_HITS + 1);

   logic                     line_start;
   logic [9:0]               line_y;
   logic [MAX_OBSTACLES-1:0] obstacle_start;
   logic signed [10:0]       obstacle_x_pos  [MAX_OBSTACLES];
   logic [9:0]               obstacle_y_pos  [MAX_OBSTACLES];
   logic [9:0]               obstacle_width  [MAX_OBSTACLES];
   logic [9:0]               obstacle_height [MAX_OBSTACLES];
   frame_t                   obstacle_frame  [MAX_OBSTACLES];
   logic                     pixel_valid;
   logic [9:0]               pixel_x;

   logic                     scan_busy;
   logic                     scan_done;
   logic [CNT_W-1:0]         hit_count;
   logic                     overflow;
   logic                     hit_valid;
   logic [SLOT_W-1:0]        hit_slot;
   logic [9:0]               hit_u;
   logic [9:0]               hit_v;
   frame_t                   hit_frame;

   modport master (
      output line_start, line_y, obstacle_start, obstacle_x_pos, obstacle_y_pos,
             obstacle_width, obstacle_height, obstacle_frame, pixel_valid, pixel_x,
      input  scan_busy, scan_done, hit_count, overflow, hit_valid, hit_slot,
             hit_u, hit_v, hit_frame
   );

   modport slave (
      input  line_start, line_y, obstacle_start, obstacle_x_pos, obstacle_y_pos,
             obstacle_width, obstacle_height, obstacle_frame, pixel_valid, pixel_x,
      output scan_busy, scan_done, hit_count, overflow, hit_valid, hit_slot,
             hit_u, hit_v, hit_frame
   );
endinterface

// File: rtl/obstacle_line_scanner.sv
// Scans the obstacle slots during blanking into a small per-line buffer, then
// resolves each active pixel to the covering obstacle and its sprite-local (u, v).
module obstacle_line_scanner
   import obstacle_pkg::*;
#(
   parameter int MAX_OBSTACLES = 7,
   parameter int MAX_HITS      = 3,
   parameter int GAME_WIDTH    = 640
) (
   input logic                    clk,
   input logic                    rst,
   obstacle_line_scanner_if.slave bus
);

   localparam int SLOT_W = (MAX_OBSTACLES > 1) ? $clog2(MAX_OBSTACLES) : 1;
   localparam int CNT_W  = $clog2(MAX_HITS + 1);
   localparam int IDX_W  = $clog2(MAX_OBSTACLES + 1);

   localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(MAX_OBSTACLES);
   localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(MAX_HITS);
   localparam logic signed [11:0] GW12     = 12'(GAME_WIDTH);

   typedef enum logic [1:0] {IDLE, SCAN, READY} state_t;

   function automatic logic signed [11:0] sx12(input logic signed [10:0] x);
      return {x[10], x};
   endfunction

   function automatic logic in_rows(input logic [9:0] y_pos, input logic [9:0] h,
                                    input logic [9:0] ly);
      logic [10:0] top, bot, row;
      top = {1'b0, y_pos};
      bot = top + {1'b0, h};
      row = {1'b0, ly};
      return (top <= row) && (row < bot);
   endfunction

   function automatic logic on_screen(input logic signed [10:0] x, input logic [9:0] w);
      logic signed [11:0] l, r;
      l = sx12(x);
      r = l + $signed({2'b00, w});
      return (r > 12'sd0) && (l < GW12);
   endfunction

   function automatic logic covers(input logic signed [10:0] x, input logic [9:0] w,
                                   input logic [9:0] px);
      logic signed [11:0] l, r, p;
      l = sx12(x);
      r = l + $signed({2'b00, w});
      p = $signed({2'b00, px});
      return (l <= p) && (p < r);
   endfunction

   state_t               state, state_next;
   logic [IDX_W-1:0]     slot_idx;
   logic [9:0]           line_y_q;
   logic [CNT_W-1:0]     hit_count_q;
   logic                 overflow_q;
   logic                 busy_q;
   logic                 done_q;

   logic [SLOT_W-1:0]    ent_slot  [MAX_HITS];
   logic signed [10:0]   ent_x     [MAX_HITS];
   logic [9:0]           ent_w     [MAX_HITS];
   logic [9:0]           ent_v     [MAX_HITS];
   frame_t               ent_frame [MAX_HITS];

   logic                 sel_start;
   logic signed [10:0]   sel_x;
   logic [9:0]           sel_y, sel_w, sel_h;
   frame_t               sel_frame;
   logic                 scanning;
   logic                 qual;

   logic                 vld_p0;
   logic [9:0]           px_p0;
   logic                 found;
   logic [SLOT_W-1:0]    f_slot;
   logic [9:0]           f_u, f_v;
   frame_t               f_frame;

   logic                 vld_p1;
   logic [SLOT_W-1:0]    slot_p1;
   logic [9:0]           u_p1, v_p1;
   frame_t               frame_p1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (bus.line_start) begin
         state_next = SCAN;
      end else begin
         unique case (state)
            IDLE:    state_next = IDLE;
            SCAN:    if (slot_idx == LAST_IDX) state_next = READY;
            READY:   state_next = READY;
            default: state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      sel_start = 1'b0;
      sel_x     = '0;
      sel_y     = '0;
      sel_w     = '0;
      sel_h     = '0;
      sel_frame = '0;
      for (int k = 0; k < MAX_OBSTACLES; k++) begin
         if (slot_idx == IDX_W'(k)) begin
            sel_start = bus.obstacle_start[k];
            sel_x     = bus.obstacle_x_pos[k];
            sel_y     = bus.obstacle_y_pos[k];
            sel_w     = bus.obstacle_width[k];
            sel_h     = bus.obstacle_height[k];
            sel_frame = bus.obstacle_frame[k];
         end
      end
   end

   assign scanning = (state == SCAN) && (slot_idx < LAST_IDX);
   assign qual     = scanning && sel_start && in_rows(sel_y, sel_h, line_y_q) &&
                     on_screen(sel_x, sel_w);

   // Scan stage: one slot per cycle into the line buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_idx    <= '0;
         line_y_q    <= '0;
         hit_count_q <= '0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int j = 0; j < MAX_HITS; j++) begin
            ent_slot[j]  <= '0;
            ent_x[j]     <= '0;
            ent_w[j]     <= '0;
            ent_v[j]     <= '0;
            ent_frame[j] <= '0;
         end
      end else if (bus.line_start) begin
         slot_idx    <= '0;
         line_y_q    <= bus.line_y;
         hit_count_q <= '0;
         overflow_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         for (int j = 0; j < MAX_HITS; j++) begin
            ent_slot[j]  <= '0;
            ent_x[j]     <= '0;
            ent_w[j]     <= '0;
            ent_v[j]     <= '0;
            ent_frame[j] <= '0;
         end
      end else begin
         busy_q <= scanning;
         done_q <= (state == SCAN) && (slot_idx == LAST_IDX);
         if (scanning) slot_idx <= slot_idx + 1'b1;
         if (qual) begin
            if (hit_count_q < FULL_CNT) begin
               for (int j = 0; j < MAX_HITS; j++) begin
                  if (hit_count_q == CNT_W'(j)) begin
                     ent_slot[j]  <= SLOT_W'(slot_idx);
                     ent_x[j]     <= sel_x;
                     ent_w[j]     <= sel_w;
                     ent_v[j]     <= line_y_q - sel_y;
                     ent_frame[j] <= sel_frame;
                  end
               end
               hit_count_q <= hit_count_q + 1'b1;
            end else begin
               overflow_q <= 1'b1;
            end
         end
      end
   end

   // Lookup stage p0: capture the pixel; a restart on the same edge kills it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_p0 <= 1'b0;
      else      vld_p0 <= bus.pixel_valid && (state == READY) && !bus.line_start;
   end

   always_ff @(posedge clk) begin
      px_p0 <= bus.pixel_x;
   end

   // Descending walk so the lowest entry (lowest slot) is the last to assign
   always_comb begin
      found   = 1'b0;
      f_slot  = '0;
      f_u     = '0;
      f_v     = '0;
      f_frame = '0;
      for (int j = MAX_HITS - 1; j >= 0; j--) begin
         if ((CNT_W'(j) < hit_count_q) && covers(ent_x[j], ent_w[j], px_p0)) begin
            found   = 1'b1;
            f_slot  = ent_slot[j];
            f_u     = px_p0 - ent_x[j][9:0];
            f_v     = ent_v[j];
            f_frame = ent_frame[j];
         end
      end
   end

   // Lookup stage p1: registered hit outputs, held on a miss
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_p1   <= 1'b0;
         slot_p1  <= '0;
         u_p1     <= '0;
         v_p1     <= '0;
         frame_p1 <= '0;
      end else begin
         vld_p1 <= vld_p0 && found;
         if (vld_p0 && found) begin
            slot_p1  <= f_slot;
            u_p1     <= f_u;
            v_p1     <= f_v;
            frame_p1 <= f_frame;
         end
      end
   end

   assign bus.scan_busy = busy_q;
   assign bus.scan_done = done_q;
   assign bus.hit_count = hit_count_q;
   assign bus.overflow  = overflow_q;
   assign bus.hit_valid = vld_p1;
   assign bus.hit_slot  = slot_p1;
   assign bus.hit_u     = u_p1;
   assign bus.hit_v     = v_p1;
   assign bus.hit_frame = frame_p1;

endmodule
